// File: rtl/nmea_stream_sender_if.sv
// Byte-stream bus of the NMEA sentence sender: load/config inputs plus the
// valid/ready character handshake and status outputs.
interface nmea_stream_sender_if #(
  parameter int B  = 8,
  parameter int L  = 32,
  parameter int LW = 6
);
  logic           load;
  logic [L*B-1:0] signal;
  logic [LW-1:0]  length;
  logic           repeat_en;
  logic           abort;
  logic           ready;
  logic           valid;
  logic [B-1:0]   data;
  logic           busy;
  logic           done;

  modport master (
    input  load, signal, length, repeat_en, abort, ready,
    output valid, data, busy, done
  );

  modport slave (
    output load, signal, length, repeat_en, abort, ready,
    input  valid, data, busy, done
  );
endinterface

// File: rtl/nmea_stream_sender.sv
// Streams one buffered NMEA sentence (char 0 first) over valid/ready, one-shot or repeating.
// Optional macro NMEA_CHECKSUM_EN replaces the two chars after '*' with the running XOR in hex.
module nmea_stream_sender #(
  parameter int B   = 8,
  parameter int L   = 32,
  parameter int LW  = 6,
  parameter int GAP = 2
) (
  input  logic clock,
  input  logic reset,
  nmea_stream_sender_if.master bus
);

  localparam int            GW       = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);
  localparam logic [LW-1:0] LMAX     = LW'(L);

  typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_GAP} state_t;

  state_t         state_q, state_d;
  logic [L*B-1:0] buf_q, buf_d;
  logic [LW-1:0]  len_q, len_d;
  logic [LW-1:0]  index_q, index_d;
  logic           rep_q, rep_d;
  logic [GW-1:0]  gap_q, gap_d;

  logic [L*B-1:0] shifted;
  int unsigned    sh_amt;
  logic [B-1:0]   cur_char;
  logic [B-1:0]   tx_char;
  logic           hs, last, start;

  // char[index] is brought to the top of the buffer by shifting left
  assign sh_amt   = 32'(index_q) * B;
  assign shifted  = buf_q << sh_amt;
  assign cur_char = shifted[L*B-1 -: B];

  assign hs    = (state_q == ST_SEND) && bus.ready;
  assign last  = (index_q == len_q - 1'b1);
  assign start = (state_q == ST_IDLE) && bus.load && (bus.length != '0) && !bus.abort;

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    len_d   = len_q;
    index_d = index_q;
    rep_d   = rep_q;
    gap_d   = gap_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          buf_d   = bus.signal;
          len_d   = (bus.length > LMAX) ? LMAX : bus.length;
          rep_d   = bus.repeat_en;
          index_d = '0;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (hs) begin
          if (!last) begin
            index_d = index_q + 1'b1;
          end else begin
            index_d = '0;
            if (!rep_q) begin
              state_d = ST_IDLE;
            end else if (GAP > 0) begin
              state_d = ST_GAP;
              gap_d   = '0;
            end
          end
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_LAST) state_d = ST_SEND;
        else                   gap_d   = gap_q + 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
    // abort wins over load and over any handshake in the same cycle
    if (bus.abort) begin
      state_d = ST_IDLE;
      index_d = '0;
    end
  end

`ifdef NMEA_CHECKSUM_EN
  localparam logic [B-1:0] CH_DOLLAR = B'(8'h24);
  localparam logic [B-1:0] CH_STAR   = B'(8'h2A);

  logic [B-1:0] acc_q, acc_d;
  logic         sum_q, sum_d;
  logic [1:0]   repl_q, repl_d;

  function automatic logic [B-1:0] hex_digit(input logic [3:0] n);
    return (n < 4'd10) ? B'(8'h30 + {4'h0, n}) : B'(8'h37 + {4'h0, n});
  endfunction

  // repl counts the characters still to be overwritten after '*'
  always_comb begin
    acc_d  = acc_q;
    sum_d  = sum_q;
    repl_d = repl_q;
    if (bus.abort || start || (hs && last)) begin
      acc_d  = '0;
      sum_d  = 1'b0;
      repl_d = 2'd0;
    end else if (hs) begin
      if (index_q == '0) begin
        acc_d  = '0;
        sum_d  = (cur_char == CH_DOLLAR);
        repl_d = 2'd0;
      end else if (sum_q) begin
        if (cur_char == CH_STAR) begin
          sum_d  = 1'b0;
          repl_d = 2'd2;
        end else begin
          acc_d = acc_q ^ cur_char;
        end
      end else if (repl_q != 2'd0) begin
        repl_d = repl_q - 2'd1;
      end
    end
  end

  always_comb begin
    tx_char = cur_char;
    if (repl_q == 2'd2)      tx_char = hex_digit(acc_q[7:4]);
    else if (repl_q == 2'd1) tx_char = hex_digit(acc_q[3:0]);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      acc_q  <= '0;
      sum_q  <= 1'b0;
      repl_q <= 2'd0;
    end else begin
      acc_q  <= acc_d;
      sum_q  <= sum_d;
      repl_q <= repl_d;
    end
  end
`else
  assign tx_char = cur_char;
`endif

  assign bus.valid = (state_q == ST_SEND);
  assign bus.data  = (state_q == ST_SEND) ? tx_char : '0;
  assign bus.busy  = (state_q != ST_IDLE);
  assign bus.done  = hs && last && !bus.abort;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      buf_q   <= '0;
      len_q   <= '0;
      index_q <= '0;
      rep_q   <= 1'b0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      len_q   <= len_d;
      index_q <= index_d;
      rep_q   <= rep_d;
      gap_q   <= gap_d;
    end
  end

endmodule

// File: tb/tb_nmea_stream_sender.sv
// Bench for nmea_stream_sender: vector table plus hand sequences (repeat/gap, abort, reset),
// with a byte scoreboard filled at load time and drained by a negedge monitor.
module tb_nmea_stream_sender;

  localparam logic [255:0] GPZDA = "$GPZDA,143042.00,25,08,2005,,*6E";
  localparam logic [255:0] Z00   = "$GPZDA,143042.00,25,08,2005,,*00";

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  nmea_stream_sender_if #(.B(8), .L(32), .LW(6)) bus ();

  nmea_stream_sender #(.B(8), .L(32), .LW(6), .GAP(2)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct { logic [7:0] ch; logic last; } exp_t;
  typedef struct { logic [255:0] s; int len; int rmode; int exp_n; } vec_t;

  exp_t sb[$];
  exp_t e;
  vec_t vt[7];
  int   tests = 0;
  int   fails = 0;
  int   rmode = 0;
  int   cyc   = 0;
  int   gap_run = 0;
  logic stall_q = 1'b0;
  logic [7:0] stall_data = '0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [255:0] lalign(input logic [255:0] v, input int n);
    return v << (8 * (32 - n));
  endfunction

  function automatic logic [7:0] hexc(input logic [3:0] n);
    return (n < 10) ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
  endfunction

  // expected characters of one sentence pass; n_push limits how many are queued
  task automatic push_sentence(input logic [255:0] s, input int n, input int n_push);
    logic [7:0] c[32];
    for (int i = 0; i < 32; i++) c[i] = s[255 - 8*i -: 8];
`ifdef NMEA_CHECKSUM_EN
    if (c[0] == 8'h24) begin
      logic [7:0] acc;
      int p;
      acc = 8'h00;
      p = -1;
      for (int i = 1; i < n; i++) begin
        if (p < 0) begin
          if (c[i] == 8'h2A) p = i;
          else acc = acc ^ c[i];
        end
      end
      if (p >= 0 && p + 1 < n) c[p+1] = hexc(acc[7:4]);
      if (p >= 0 && p + 2 < n) c[p+2] = hexc(acc[3:0]);
    end
`endif
    for (int i = 0; i < n_push; i++) sb.push_back('{ch: c[i], last: (i == n - 1)});
  endtask

  task automatic do_load(input logic [255:0] s, input int len, input logic rep);
    @(posedge clock); #1;
    bus.load = 1'b1; bus.signal = s; bus.length = 6'(len); bus.repeat_en = rep;
    @(posedge clock); #1;
    bus.load = 1'b0;
  endtask

  task automatic wait_idle(input string nm, output int c);
    c = 0;
    while (bus.busy && c < 400) begin @(posedge clock); #1; c++; end
    check({nm, "_timeout"}, (c < 400), 1);
  endtask

  task automatic wait_sb(input string nm, input int left);
    int c;
    c = 0;
    while (sb.size() > left && c < 400) begin @(negedge clock); #1; c++; end
    check({nm, "_timeout"}, (c < 400), 1);
  endtask

  // ready pattern: 0 = always, 1 = 1,0,0 repeating, 2 = random
  initial begin
    bus.ready = 1'b1;
    forever begin
      @(posedge clock); #1;
      cyc++;
      case (rmode)
        1:       bus.ready = (cyc % 3 == 0);
        2:       bus.ready = 1'($urandom_range(0, 1));
        default: bus.ready = 1'b1;
      endcase
    end
  end

  always @(negedge clock) begin
    if (reset && !bus.abort) begin
      if (bus.valid && bus.ready) begin
        if (sb.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_hs: got data %0h, required no handshake (t=%0t)", bus.data, $time);
        end else begin
          e = sb.pop_front();
          check("data", bus.data, e.ch);
          check("done", bus.done, e.last);
        end
      end else begin
        check("done_quiet", bus.done, 0);
        if (!bus.valid) check("data_zero", bus.data, 0);
      end
      if (stall_q && bus.valid) check("stall_hold", bus.data, stall_data);
      stall_q    = bus.valid && !bus.ready;
      stall_data = bus.data;
      if (!bus.busy) gap_run = 0;
      else if (!bus.valid) gap_run++;
      else if (gap_run != 0) begin
        check("gap_len", gap_run, 2);
        gap_run = 0;
      end
    end else begin
      if (bus.abort) check("done_abort", bus.done, 0);
      stall_q = 1'b0;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, n;
    vt[0] = '{GPZDA,                 32, 0, 32};
    vt[1] = '{GPZDA,                 32, 1, 32};
    vt[2] = '{GPZDA,                 40, 0, 32};
    vt[3] = '{GPZDA,                  0, 0,  0};
    vt[4] = '{lalign("$GP", 3),       3, 2,  3};
    vt[5] = '{lalign("GPZDA*12", 8),  8, 2,  8};
    vt[6] = '{Z00,                   32, 2, 32};

    reset = 1'b0;
    bus.load = 1'b0; bus.signal = '0; bus.length = '0; bus.repeat_en = 1'b0; bus.abort = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_valid", bus.valid, 0);
    check("rst_data",  bus.data,  0);
    check("rst_busy",  bus.busy,  0);
    check("rst_done",  bus.done,  0);
    reset = 1'b1;

    for (int k = 0; k < 7; k++) begin
      rmode = vt[k].rmode;
      n = (vt[k].len > 32) ? 32 : vt[k].len;
      push_sentence(vt[k].s, n, n);
      do_load(vt[k].s, vt[k].len, 1'b0);
      check("load_busy", bus.busy, (vt[k].exp_n != 0));
      wait_idle("vec", c);
      if (vt[k].rmode == 0) check("busy_cycles", c, vt[k].exp_n);
      check("vec_drained", sb.size(), 0);
      rmode = 0;
      repeat (2) @(posedge clock);
    end

    // repeat with gap, abort during the third sentence
    rmode = 0;
    push_sentence(lalign("$GPZD", 5), 5, 5);
    push_sentence(lalign("$GPZD", 5), 5, 5);
    push_sentence(lalign("$GPZD", 5), 5, 2);
    do_load(lalign("$GPZD", 5), 5, 1'b1);
    wait_sb("rep", 0);
    @(posedge clock); #1;
    bus.abort = 1'b1;
    @(posedge clock); #1;
    bus.abort = 1'b0;
    check("abort_valid", bus.valid, 0);
    check("abort_busy",  bus.busy,  0);
    check("abort_done",  bus.done,  0);

    // abort on the final character: handshake discarded, no done
    push_sentence(lalign("$GP", 3), 3, 2);
    do_load(lalign("$GP", 3), 3, 1'b0);
    wait_sb("abl", 0);
    @(posedge clock); #1;
    bus.abort = 1'b1;
    @(posedge clock); #1;
    bus.abort = 1'b0;
    check("abl_busy", bus.busy, 0);
    repeat (3) @(posedge clock);

    // load while busy is ignored
    push_sentence(GPZDA, 10, 10);
    do_load(GPZDA, 10, 1'b0);
    repeat (3) @(posedge clock);
    #1;
    bus.load = 1'b1; bus.signal = lalign("ABCD", 4); bus.length = 6'd4;
    @(posedge clock); #1;
    bus.load = 1'b0;
    wait_idle("lwb", c);
    repeat (5) @(posedge clock);
    #1;
    check("lwb_drained", sb.size(), 0);
    check("lwb_busy", bus.busy, 0);

    // synchronous reset mid-sentence, then a fresh load starts at char 0
    push_sentence(GPZDA, 20, 20);
    do_load(GPZDA, 20, 1'b0);
    wait_sb("rst", 15);
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    sb.delete();
    check("mrst_valid", bus.valid, 0);
    check("mrst_busy",  bus.busy,  0);
    check("mrst_done",  bus.done,  0);
    check("mrst_data",  bus.data,  0);
    push_sentence(lalign("$GP", 3), 3, 3);
    do_load(lalign("$GP", 3), 3, 1'b0);
    wait_idle("post_rst", c);
    check("post_rst_drained", sb.size(), 0);

    repeat (3) @(posedge clock);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
